// File: rtl/dist_ascii_pkg.sv
// Shared types and constants for the distance-to-ASCII framer slice.
package dist_ascii_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_DIGITS = 5;
    localparam int DEF_DROP_W = 8;
    localparam int FRAME_LEN  = DEF_DIGITS + 2;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        SEND    = 2'd2
    } state_t;

endpackage

// File: rtl/dist_ascii_framer_if.sv
// Sample-in / byte-out bundle between the sensor, the framer and the UART.
interface dist_ascii_framer_if
    import dist_ascii_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DROP_W = DEF_DROP_W
);

    logic              dist_valid;
    logic [DATA_W-1:0] dist_in;
    logic              dist_ready;
    logic [7:0]        tx_byte;
    logic              tx_valid;
    logic              tx_ready;
    logic              busy;
    logic [DROP_W-1:0] drop_cnt;

    modport master (
        input  dist_valid, dist_in, tx_ready,
        output dist_ready, tx_byte, tx_valid, busy, drop_cnt
    );

    modport slave (
        output dist_valid, dist_in, tx_ready,
        input  dist_ready, tx_byte, tx_valid, busy, drop_cnt
    );

endinterface

// File: rtl/dist_ascii_framer_bin2bcd_seq.sv
// Sequential double-dabble converter: one shift-add-3 step per clock, DATA_W steps per sample.
module bin2bcd_seq
    import dist_ascii_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DIGITS = DEF_DIGITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_W-1:0]     bin_in,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out
);

    localparam int BCD_W  = 4 * DIGITS;
    localparam int ITER_W = $clog2(DATA_W) + 1;

    logic [DATA_W-1:0] shift_r;
    logic [BCD_W-1:0]  bcd_r;
    logic [BCD_W-1:0]  bcd_adj_s;
    logic [ITER_W-1:0] iter_r;
    logic              run_r;
    logic              done_r;

    function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] res;
        res = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end else begin
                res[4*i +: 4] = bcd[4*i +: 4];
            end
        end
        return res;
    endfunction

    // Add-3 correction applied to every nibble before the next shift
    always_comb begin
        bcd_adj_s = bcd_adjust(bcd_r);
    end

    // Iteration state: load on start, then shift until DATA_W steps are done
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_r <= '0;
            bcd_r   <= '0;
            iter_r  <= '0;
            run_r   <= 1'b0;
            done_r  <= 1'b0;
        end else if (start) begin
            shift_r <= bin_in;
            bcd_r   <= '0;
            iter_r  <= '0;
            run_r   <= 1'b1;
            done_r  <= 1'b0;
        end else if (run_r) begin
            bcd_r   <= {bcd_adj_s[BCD_W-2:0], shift_r[DATA_W-1]};
            shift_r <= {shift_r[DATA_W-2:0], 1'b0};
            iter_r  <= iter_r + ITER_W'(1);
            if (iter_r == ITER_W'(DATA_W - 1)) begin
                run_r  <= 1'b0;
                done_r <= 1'b1;
            end else begin
                done_r <= 1'b0;
            end
        end else begin
            done_r <= 1'b0;
        end
    end

    assign done    = done_r;
    assign bcd_out = bcd_r;

endmodule

// File: rtl/dist_ascii_framer.sv
// Captures a distance sample, converts it to BCD and streams "DDDDD\r\n" over valid/ready.
module dist_ascii_framer
    import dist_ascii_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DIGITS = DEF_DIGITS,
    parameter int DROP_W = DEF_DROP_W
) (
    input  logic               clk,
    input  logic               rst,
    dist_ascii_framer_if.master bus
);

    localparam int BCD_W   = 4 * DIGITS;
    localparam int FRAME_N = DIGITS + 2;
    localparam int IDX_W   = $clog2(FRAME_N);

    state_t            state_r;
    state_t            state_s;
    logic [IDX_W-1:0]  idx_r;
    logic [DROP_W-1:0] drop_r;
    logic              start_s;
    logic              accept_s;
    logic              last_s;
    logic              conv_done_s;
    logic [BCD_W-1:0]  bcd_s;
    logic [BCD_W-1:0]  bcd_shift_s;

    // Handshake qualifiers shared by the FSM and the counters
    always_comb begin
        start_s  = (state_r == IDLE) && bus.dist_valid;
        accept_s = (state_r == SEND) && bus.tx_ready;
        last_s   = (idx_r == IDX_W'(FRAME_N - 1));
    end

    bin2bcd_seq #(
        .DATA_W (DATA_W),
        .DIGITS (DIGITS)
    ) u_bin2bcd (
        .clk     (clk),
        .rst     (rst),
        .start   (start_s),
        .bin_in  (bus.dist_in),
        .done    (conv_done_s),
        .bcd_out (bcd_s)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.dist_valid) state_s = CONVERT;
                else                state_s = IDLE;
            end
            CONVERT: begin
                if (conv_done_s) state_s = SEND;
                else             state_s = CONVERT;
            end
            SEND: begin
                if (accept_s && last_s) state_s = IDLE;
                else                    state_s = SEND;
            end
            default: state_s = IDLE;
        endcase
    end

    // Byte index within the frame; advances only on an accepted byte
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_r <= '0;
        end else if (state_r != SEND) begin
            idx_r <= '0;
        end else if (accept_s) begin
            idx_r <= last_s ? '0 : idx_r + IDX_W'(1);
        end else begin
            idx_r <= idx_r;
        end
    end

    // Saturating count of strobes that arrive while a frame is in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_r <= '0;
        end else if (bus.dist_valid && (state_r != IDLE) && (drop_r != '1)) begin
            drop_r <= drop_r + DROP_W'(1);
        end else begin
            drop_r <= drop_r;
        end
    end

    // Outputs decode only registered state, so they are glitch-free and stable under backpressure
    always_comb begin
        bus.dist_ready = 1'b0;
        bus.busy       = 1'b0;
        bus.tx_valid   = 1'b0;
        bus.tx_byte    = 8'h00;
        bcd_shift_s    = bcd_s << {idx_r, 2'b00};
        case (state_r)
            IDLE: begin
                bus.dist_ready = 1'b1;
            end
            CONVERT: begin
                bus.busy = 1'b1;
            end
            SEND: begin
                bus.busy     = 1'b1;
                bus.tx_valid = 1'b1;
                if (idx_r < IDX_W'(DIGITS)) begin
                    bus.tx_byte = ASCII_ZERO + {4'h0, bcd_shift_s[BCD_W-1 -: 4]};
                end else if (idx_r == IDX_W'(DIGITS)) begin
                    bus.tx_byte = ASCII_CR;
                end else begin
                    bus.tx_byte = ASCII_LF;
                end
            end
            default: begin
                bus.dist_ready = 1'b0;
            end
        endcase
    end

    assign bus.drop_cnt = drop_r;

endmodule
